// File: rtl/job_fetcher_pkg.sv
// Shared types and AXI constants for the descriptor fetcher.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package job_fetcher_pkg;

  // Fetch sequencer states
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ADDR     = 3'd1,
    ST_DATA     = 3'd2,
    ST_DISPATCH = 3'd3,
    ST_DONE     = 3'd4,
    ST_ERROR    = 3'd5
  } fetch_state_t;

  // One descriptor is exactly one 64-byte AXI beat
  localparam int unsigned DESC_BYTES    = 64;
  localparam logic [2:0]  AR_SIZE_64B   = 3'b110;
  localparam logic [7:0]  AR_LEN_SINGLE = 8'd0;
  localparam logic [1:0]  AR_BURST_INCR = 2'b01;
  localparam logic [3:0]  AR_CACHE_VAL  = 4'b0011;
  localparam logic [2:0]  AR_PROT_VAL   = 3'b000;
  localparam logic [3:0]  AR_QOS_VAL    = 4'b0000;
  localparam logic [3:0]  AR_REGION_VAL = 4'b0000;
  localparam logic [1:0]  RESP_OKAY     = 2'b00;

  // Advance a ring offset by one descriptor, wrapping at the ring size
  function automatic logic [31:0] next_offset(input logic [31:0] off,
                                              input logic [31:0] size);
    logic [31:0] inc;
    inc = off + 32'(DESC_BYTES);
    return (inc == size) ? 32'd0 : inc;
  endfunction

endpackage

// File: rtl/job_fetcher_if.sv
// AXI4 read address + read data bundle between the fetcher and memory.
// Latency: wires only.
// Backpressure: arvalid/arready on AR, rvalid/rready on R.
interface job_fetcher_if #(
  parameter int ID_WIDTH     = 1,
  parameter int ARUSER_WIDTH = 8,
  parameter int DATA_WIDTH   = 512,
  parameter int ADDR_WIDTH   = 64
);

  logic [ID_WIDTH-1:0]     arid;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [7:0]              arlen;
  logic [2:0]              arsize;
  logic [1:0]              arburst;
  logic [3:0]              arcache;
  logic                    arlock;
  logic [2:0]              arprot;
  logic [3:0]              arqos;
  logic [3:0]              arregion;
  logic [ARUSER_WIDTH-1:0] aruser;
  logic                    arvalid;
  logic                    arready;

  logic [ID_WIDTH-1:0]     rid;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rlast;
  logic                    rvalid;
  logic                    rready;

  // Fetcher side: issues reads, sinks data
  modport master (
    output arid, araddr, arlen, arsize, arburst, arcache, arlock,
           arprot, arqos, arregion, aruser, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  // Memory side: accepts reads, returns data
  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arcache, arlock,
           arprot, arqos, arregion, aruser, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );

endinterface

// File: rtl/job_fetcher_free_kernel_picker.sv
// Picks the lowest-index idle kernel as a one-hot vector.
// Latency: combinational.
// Backpressure: none; any_free low means no kernel may be started.
module free_kernel_picker #(
  parameter int KERNEL_NUM = 8
) (
  input  logic [KERNEL_NUM-1:0] kernel_busy,
  output logic [KERNEL_NUM-1:0] pick,
  output logic                  any_free
);

  logic [KERNEL_NUM-1:0] free;

  assign free     = ~kernel_busy;
  // Two's-complement trick isolates the least significant set bit
  assign pick     = free & (~free + KERNEL_NUM'(1));
  assign any_free = |free;

endmodule

// File: rtl/job_fetcher.sv
// Walks a descriptor ring over AXI (one 64B beat per job) and starts a free kernel per descriptor.
// Latency: >=4 cycles per job (AR, R, pick, pulse) plus memory latency and kernel-busy stalls.
// Backpressure: holds arvalid until arready; waits in dispatch while every kernel is busy.
module job_fetcher
  import job_fetcher_pkg::*;
#(
  parameter int KERNEL_NUM   = 8,
  parameter int ID_WIDTH     = 1,
  parameter int ARUSER_WIDTH = 8,
  parameter int DATA_WIDTH   = 512,
  parameter int ADDR_WIDTH   = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fetch_enable,
  input  logic [63:0]           job_addr,
  input  logic [31:0]           job_size,
  input  logic [31:0]           job_count,
  input  logic [KERNEL_NUM-1:0] kernel_busy,
  output logic [KERNEL_NUM-1:0] kernel_start,
  output logic [DATA_WIDTH-1:0] system_register,
  output logic                  fetch_done,
  output logic                  fetch_error,
  job_fetcher_if.master         m_axi
);

  fetch_state_t          state;
  logic [31:0]           rd_offset;
  logic [31:0]           jobs_left;
  logic                  session_done;
  logic                  arvalid_q;
  logic [KERNEL_NUM-1:0] pick;
  logic                  any_free;
  logic                  unused_r;

  free_kernel_picker #(
    .KERNEL_NUM (KERNEL_NUM)
  ) u_picker (
    .kernel_busy (kernel_busy),
    .pick        (pick),
    .any_free    (any_free)
  );

  // Fixed single-beat, 64B, incrementing, bufferable/modifiable read requests
  assign m_axi.arid     = ID_WIDTH'(0);
  assign m_axi.arlen    = AR_LEN_SINGLE;
  assign m_axi.arsize   = AR_SIZE_64B;
  assign m_axi.arburst  = AR_BURST_INCR;
  assign m_axi.arcache  = AR_CACHE_VAL;
  assign m_axi.arlock   = 1'b0;
  assign m_axi.arprot   = AR_PROT_VAL;
  assign m_axi.arqos    = AR_QOS_VAL;
  assign m_axi.arregion = AR_REGION_VAL;
  assign m_axi.aruser   = ARUSER_WIDTH'(0);
  assign m_axi.arvalid  = arvalid_q;
  // Address wraps silently; rd_offset only changes between requests so araddr is stable while valid
  assign m_axi.araddr   = ADDR_WIDTH'(job_addr + {32'd0, rd_offset});
  // Only one read is ever outstanding, so data is always accepted
  assign m_axi.rready   = 1'b1;

  // Single-beat reads with a single outstanding request make rid/rlast redundant
  assign unused_r = ^{m_axi.rid, m_axi.rlast};

  // Fetch sequencer: request, receive, dispatch, advance; all outputs registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= ST_IDLE;
      kernel_start    <= '0;
      system_register <= '0;
      fetch_done      <= 1'b0;
      fetch_error     <= 1'b0;
      arvalid_q       <= 1'b0;
      rd_offset       <= 32'd0;
      jobs_left       <= 32'd0;
      session_done    <= 1'b0;
    end else begin
      kernel_start <= '0;
      fetch_done   <= 1'b0;
      // Dropping enable re-arms the block for the next session
      if (!fetch_enable) begin
        session_done <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (fetch_enable && (job_count != 32'd0) && !session_done) begin
            jobs_left <= job_count;
            rd_offset <= 32'd0;
            arvalid_q <= 1'b1;
            state     <= ST_ADDR;
          end
        end

        // Request stays up until accepted, even if the session is abandoned
        ST_ADDR: begin
          if (arvalid_q && m_axi.arready) begin
            arvalid_q <= 1'b0;
            state     <= ST_DATA;
          end
        end

        // The beat is always consumed; an abandoned session just discards it
        ST_DATA: begin
          if (m_axi.rvalid) begin
            if (m_axi.rresp != RESP_OKAY) begin
              fetch_error <= 1'b1;
              state       <= ST_ERROR;
            end else begin
              system_register <= m_axi.rdata;
              state           <= fetch_enable ? ST_DISPATCH : ST_IDLE;
            end
          end
        end

        // First cycle picks a kernel; the pulse cycle advances the ring.
        // The pick can never follow a pulse directly, so kernel_busy has settled.
        ST_DISPATCH: begin
          if (kernel_start != '0) begin
            rd_offset <= next_offset(rd_offset, job_size);
            jobs_left <= jobs_left - 32'd1;
            if (jobs_left == 32'd1) begin
              fetch_done <= 1'b1;
              state      <= ST_DONE;
            end else if (!fetch_enable) begin
              state <= ST_IDLE;
            end else begin
              arvalid_q <= 1'b1;
              state     <= ST_ADDR;
            end
          end else if (!fetch_enable) begin
            state <= ST_IDLE;
          end else if (any_free) begin
            kernel_start <= pick;
          end
        end

        // fetch_done is high for exactly this cycle
        ST_DONE: begin
          session_done <= 1'b1;
          state        <= ST_IDLE;
        end

        // Error is sticky until software closes the session
        ST_ERROR: begin
          if (!fetch_enable) begin
            fetch_error <= 1'b0;
            state       <= ST_IDLE;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_job_fetcher.sv
// Self-checking bench for job_fetcher: AXI memory model, kernel model, per-scenario tasks.
// Latency: n/a.
// Backpressure: memory model inserts random arready/rvalid delays.
module tb_job_fetcher;

  localparam int KN = 8;
  localparam int DW = 512;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          fetch_enable;
  logic [63:0]   job_addr;
  logic [31:0]   job_size;
  logic [31:0]   job_count;
  logic [KN-1:0] kernel_busy;
  logic [KN-1:0] kernel_start;
  logic [DW-1:0] system_register;
  logic          fetch_done;
  logic          fetch_error;

  job_fetcher_if #(.ID_WIDTH(1), .ARUSER_WIDTH(8), .DATA_WIDTH(DW), .ADDR_WIDTH(64)) axi ();

  job_fetcher #(
    .KERNEL_NUM(KN), .ID_WIDTH(1), .ARUSER_WIDTH(8), .DATA_WIDTH(DW), .ADDR_WIDTH(64)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .fetch_enable    (fetch_enable),
    .job_addr        (job_addr),
    .job_size        (job_size),
    .job_count       (job_count),
    .kernel_busy     (kernel_busy),
    .kernel_start    (kernel_start),
    .system_register (system_register),
    .fetch_done      (fetch_done),
    .fetch_error     (fetch_error),
    .m_axi           (axi)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Observations collected by the monitor
  logic [63:0]   ar_q[$];
  logic [KN-1:0] st_q[$];
  logic [KN-1:0] st_exp_q[$];
  bit            st_dat_ok_q[$];
  int            done_cnt     = 0;
  int            beats        = 0;
  int            spacing_viol = 0;
  int            hold_viol    = 0;
  int            gap          = 100;
  logic [DW-1:0] last_beat_dat = '0;
  logic [KN-1:0] busy_snap;

  // Knobs set by the scenario tasks
  int            ar_dmax  = 0;
  int            r_dmin   = 0;
  int            r_dmax   = 0;
  int            busy_min = 1;
  int            busy_max = 1;
  bit            ar_hold  = 1'b0;
  int            err_at   = -1;
  bit            force_en = 1'b0;
  logic [KN-1:0] force_val = '0;
  int            clr_gen  = 0;

  // Model-internal state
  int            ar_wait = 0, ar_target = 0, r_wait = 0;
  bit            r_pend = 1'b0;
  bit            prev_av = 1'b0, prev_rdy = 1'b0;
  logic [63:0]   prev_addr = '0;
  int            busy_cnt[KN];
  int            clr_seen = 0;
  logic [KN-1:0] model_busy = '0;

  assign kernel_busy = force_en ? force_val : model_busy;

  // Busy vector exactly as the DUT sampled it at this edge
  always @(posedge clk) busy_snap <= kernel_busy;

  // Monitor, AXI memory model and kernel model, all evaluated mid-cycle
  always @(negedge clk) begin
    logic [KN-1:0] exp;
    logic [DW-1:0] dat;
    bit found;
    if (!rst_n) begin
      axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rresp = 2'b00;
      axi.rdata = '0; axi.rid = 1'b0; axi.rlast = 1'b1;
      r_pend = 1'b0; ar_wait = 0; prev_av = 1'b0; prev_rdy = 1'b0; gap = 100;
      for (int k = 0; k < KN; k++) busy_cnt[k] = 0;
    end else begin
      // monitor
      if (fetch_done) done_cnt++;
      gap++;
      if (kernel_start != '0) begin
        if (gap < 2) spacing_viol++;
        gap = 0;
        exp = '0; found = 1'b0;
        for (int k = 0; k < KN; k++)
          if (!found && !busy_snap[k]) begin exp[k] = 1'b1; found = 1'b1; end
        st_q.push_back(kernel_start);
        st_exp_q.push_back(exp);
        st_dat_ok_q.push_back(system_register === last_beat_dat);
      end
      if (prev_av && !prev_rdy && (axi.arvalid !== 1'b1 || axi.araddr !== prev_addr)) hold_viol++;
      // read data channel: a beat driven last negedge was taken at the edge since
      if (axi.rvalid) begin
        axi.rvalid = 1'b0;
      end else if (r_pend) begin
        if (r_wait > 0) r_wait--;
        else begin
          for (int w = 0; w < DW / 32; w++) dat[w*32 +: 32] = $urandom;
          axi.rdata  = dat;
          axi.rresp  = (beats == err_at) ? 2'b10 : 2'b00;
          axi.rvalid = 1'b1;
          last_beat_dat = dat;
          beats++;
          r_pend = 1'b0;
        end
      end
      // read address channel: single-cycle arready while arvalid is up
      if (axi.arready) begin
        axi.arready = 1'b0;
      end else if (axi.arvalid && !ar_hold) begin
        if (ar_wait >= ar_target) begin
          axi.arready = 1'b1;
          ar_q.push_back(axi.araddr);
          r_pend    = 1'b1;
          r_wait    = int'($urandom_range(r_dmax, r_dmin));
          ar_wait   = 0;
          ar_target = int'($urandom_range(ar_dmax, 0));
        end else ar_wait++;
      end
      prev_av = axi.arvalid; prev_rdy = axi.arready; prev_addr = axi.araddr;
      // kernels: busy from the cycle after their start pulse
      if (clr_gen != clr_seen) begin
        clr_seen = clr_gen;
        for (int k = 0; k < KN; k++) busy_cnt[k] = 0;
      end else begin
        for (int k = 0; k < KN; k++) if (busy_cnt[k] > 0) busy_cnt[k]--;
        for (int k = 0; k < KN; k++)
          if (kernel_start[k]) busy_cnt[k] = int'($urandom_range(busy_max, busy_min));
      end
    end
    for (int k = 0; k < KN; k++) model_busy[k] = (busy_cnt[k] != 0);
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clr_models();
    clr_gen++;
    cyc(2);
  endtask

  task automatic start_session(input logic [63:0] a, input logic [31:0] s, input logic [31:0] c);
    @(posedge clk); #1;
    job_addr = a; job_size = s; job_count = c; fetch_enable = 1'b1;
  endtask

  task automatic stop_session();
    @(posedge clk); #1;
    fetch_enable = 1'b0;
    cyc(3);
  endtask

  task automatic wait_end(input int budget, output bit ok);
    int d0;
    d0 = done_cnt;
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      cyc(1);
      if (done_cnt != d0 || fetch_error) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; fetch_enable = 1'b0; job_addr = '0; job_size = 32'd64; job_count = '0;
    cyc(3);
    total++; if (kernel_start !== '0) $display("FAIL reset_kernel_start: got %h expected 0", kernel_start); else passed++;
    total++; if (system_register !== '0) $display("FAIL reset_system_register: got nonzero expected 0"); else passed++;
    total++; if ({fetch_done, fetch_error} !== 2'b00) $display("FAIL reset_done_error: got %b expected 00", {fetch_done, fetch_error}); else passed++;
    total++; if (axi.arvalid !== 1'b0) $display("FAIL reset_arvalid: got %b expected 0", axi.arvalid); else passed++;
    total++; if (axi.rready !== 1'b1) $display("FAIL rready_const: got %b expected 1", axi.rready); else passed++;
    total++; if ({axi.arlen, axi.arsize, axi.arburst, axi.arcache} !== {8'd0, 3'b110, 2'b01, 4'b0011})
      $display("FAIL ar_constants: got %h expected %h", {axi.arlen, axi.arsize, axi.arburst, axi.arcache}, {8'd0, 3'b110, 2'b01, 4'b0011}); else passed++;
    total++; if ({axi.arid, axi.arlock, axi.arprot, axi.arqos, axi.arregion, axi.aruser} !== '0)
      $display("FAIL ar_zero_fields: got %h expected 0", {axi.arid, axi.arlock, axi.arprot, axi.arqos, axi.arregion, axi.aruser}); else passed++;
    @(posedge clk); #1; rst_n = 1'b1;
    cyc(3);
  endtask

  task automatic test_basic();
    logic [7:0] exp_st[3];
    int a0, s0, d0;
    bit ok;
    exp_st = '{8'h01, 8'h02, 8'h04};
    clr_models();
    busy_min = 2000; busy_max = 2000; ar_dmax = 0; r_dmin = 0; r_dmax = 0;
    a0 = ar_q.size(); s0 = st_q.size(); d0 = done_cnt;
    start_session(64'h1000, 32'd256, 32'd3);
    wait_end(400, ok);
    total++; if (!ok) $display("FAIL basic_timeout: got no end expected fetch_done"); else passed++;
    stop_session();
    total++; if (ar_q.size() - a0 != 3) $display("FAIL basic_ar_count: got %0d expected 3", ar_q.size() - a0); else passed++;
    for (int i = 0; i < 3; i++) begin
      logic [63:0] e, g;
      e = 64'h1000 + 64'(i * 64);
      g = (a0 + i < ar_q.size()) ? ar_q[a0 + i] : 'x;
      total++; if (g !== e) $display("FAIL basic_araddr[%0d]: got %h expected %h", i, g, e); else passed++;
    end
    total++; if (st_q.size() - s0 != 3) $display("FAIL basic_start_count: got %0d expected 3", st_q.size() - s0); else passed++;
    for (int i = 0; i < 3; i++) begin
      logic [7:0] g;
      g = (s0 + i < st_q.size()) ? st_q[s0 + i] : 'x;
      total++; if (g !== exp_st[i]) $display("FAIL basic_kernel_start[%0d]: got %h expected %h", i, g, exp_st[i]); else passed++;
      total++; if (s0 + i >= st_q.size() || !st_dat_ok_q[s0 + i]) $display("FAIL basic_sysreg[%0d]: got stale expected fetched rdata", i); else passed++;
    end
    total++; if (done_cnt - d0 != 1) $display("FAIL basic_done_count: got %0d expected 1", done_cnt - d0); else passed++;
  endtask

  // Random session: addresses from the ring rule, starts from the lowest-free rule
  task automatic run_checked(input string nm, input logic [63:0] a, input int sz, input int cnt);
    int a0, s0, d0;
    bit ok;
    a0 = ar_q.size(); s0 = st_q.size(); d0 = done_cnt;
    start_session(a, 32'(sz), 32'(cnt));
    wait_end(3000, ok);
    total++; if (!ok) $display("FAIL %s_timeout: got no end expected fetch_done", nm); else passed++;
    total++; if (fetch_error !== 1'b0) $display("FAIL %s_error: got %b expected 0", nm, fetch_error); else passed++;
    stop_session();
    total++; if (ar_q.size() - a0 != cnt) $display("FAIL %s_ar_count: got %0d expected %0d", nm, ar_q.size() - a0, cnt); else passed++;
    for (int i = 0; i < cnt; i++) begin
      logic [63:0] e, g;
      e = a + 64'((i * 64) % sz);
      g = (a0 + i < ar_q.size()) ? ar_q[a0 + i] : 'x;
      total++; if (g !== e) $display("FAIL %s_araddr[%0d]: got %h expected %h", nm, i, g, e); else passed++;
    end
    total++; if (st_q.size() - s0 != cnt) $display("FAIL %s_start_count: got %0d expected %0d", nm, st_q.size() - s0, cnt); else passed++;
    for (int i = s0; i < st_q.size(); i++) begin
      total++; if (st_q[i] !== st_exp_q[i]) $display("FAIL %s_pick[%0d]: got %h expected %h", nm, i - s0, st_q[i], st_exp_q[i]); else passed++;
      total++; if (!st_dat_ok_q[i]) $display("FAIL %s_sysreg[%0d]: got stale expected fetched rdata", nm, i - s0); else passed++;
    end
    total++; if (done_cnt - d0 != 1) $display("FAIL %s_done_count: got %0d expected 1", nm, done_cnt - d0); else passed++;
  endtask

  task automatic test_wrap();
    clr_models();
    busy_min = 1; busy_max = 6; ar_dmax = 2; r_dmin = 0; r_dmax = 2;
    run_checked("wrap", 64'h1000, 128, 5);
  endtask

  task automatic test_random();
    for (int n = 0; n < 6; n++) begin
      logic [63:0] a;
      clr_models();
      a = {$urandom, $urandom} & ~64'h3F;
      busy_min = 1; busy_max = int'($urandom_range(40, 1));
      ar_dmax = int'($urandom_range(3, 0)); r_dmin = 0; r_dmax = int'($urandom_range(3, 0));
      run_checked("random", a, 64 * int'($urandom_range(8, 1)), int'($urandom_range(12, 1)));
    end
  endtask

  task automatic test_back_to_back();
    int sv0;
    clr_models();
    sv0 = spacing_viol;
    busy_min = 1; busy_max = 1; ar_dmax = 0; r_dmin = 0; r_dmax = 0;
    run_checked("b2b", 64'h8000, 512, 10);
    total++; if (spacing_viol != sv0) $display("FAIL b2b_start_spacing: got %0d violations expected 0", spacing_viol - sv0); else passed++;
  endtask

  task automatic test_busy_wait();
    int s0, d0;
    bit ok;
    clr_models();
    ar_dmax = 0; r_dmin = 0; r_dmax = 0;
    force_en = 1'b1; force_val = 8'hFF;
    s0 = st_q.size(); d0 = done_cnt;
    start_session(64'h2000, 32'd64, 32'd1);
    cyc(20);
    total++; if (st_q.size() != s0) $display("FAIL busywait_no_start: got %0d starts expected 0", st_q.size() - s0); else passed++;
    force_val = 8'h7F;
    wait_end(100, ok);
    total++; if (!ok) $display("FAIL busywait_timeout: got no end expected fetch_done"); else passed++;
    total++; if (st_q.size() - s0 != 1 || st_q[s0] !== 8'h80)
      $display("FAIL busywait_start: got %0d starts first %h expected 1 start of 80", st_q.size() - s0, (st_q.size() > s0) ? st_q[s0] : 8'h00); else passed++;
    total++; if (st_q.size() <= s0 || !st_dat_ok_q[s0]) $display("FAIL busywait_sysreg: got stale expected fetched rdata"); else passed++;
    total++; if (done_cnt - d0 != 1) $display("FAIL busywait_done: got %0d expected 1", done_cnt - d0); else passed++;
    force_en = 1'b0;
    stop_session();
  endtask

  task automatic test_error();
    int a0, s0, d0;
    bit ok;
    clr_models();
    busy_min = 1000; busy_max = 1000; ar_dmax = 1; r_dmin = 0; r_dmax = 1;
    a0 = ar_q.size(); s0 = st_q.size(); d0 = done_cnt;
    err_at = beats + 1;
    start_session(64'h3000, 32'd256, 32'd3);
    wait_end(300, ok);
    total++; if (!ok) $display("FAIL error_timeout: got no end expected fetch_error"); else passed++;
    cyc(10);
    total++; if (fetch_error !== 1'b1) $display("FAIL error_sticky: got %b expected 1", fetch_error); else passed++;
    total++; if (st_q.size() - s0 != 1) $display("FAIL error_start_count: got %0d expected 1", st_q.size() - s0); else passed++;
    total++; if (ar_q.size() - a0 != 2) $display("FAIL error_ar_count: got %0d expected 2", ar_q.size() - a0); else passed++;
    total++; if (done_cnt != d0) $display("FAIL error_no_done: got %0d dones expected 0", done_cnt - d0); else passed++;
    stop_session();
    err_at = -1;
    total++; if (fetch_error !== 1'b0) $display("FAIL error_clear: got %b expected 0", fetch_error); else passed++;
  endtask

  task automatic test_abort();
    int a0, s0, d0, b0;
    bit got;
    clr_models();
    ar_dmax = 0; r_dmin = 2; r_dmax = 2; hold_viol = 0;
    a0 = ar_q.size(); s0 = st_q.size(); d0 = done_cnt; b0 = beats;
    ar_hold = 1'b1;
    start_session(64'h4000, 32'd256, 32'd2);
    cyc(4);
    fetch_enable = 1'b0;
    cyc(6);
    total++; if (axi.arvalid !== 1'b1) $display("FAIL abort_arvalid_held: got %b expected 1", axi.arvalid); else passed++;
    ar_hold = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 50 && !got; c++) begin cyc(1); got = (beats != b0); end
    total++; if (!got) $display("FAIL abort_beat: got no beat expected one"); else passed++;
    cyc(6);
    total++; if (axi.arvalid !== 1'b0 || ar_q.size() - a0 != 1)
      $display("FAIL abort_idle: got arvalid %b reads %0d expected 0 and 1", axi.arvalid, ar_q.size() - a0); else passed++;
    total++; if (st_q.size() != s0 || done_cnt != d0)
      $display("FAIL abort_no_pulse: got %0d starts %0d dones expected 0", st_q.size() - s0, done_cnt - d0); else passed++;
    total++; if (hold_viol != 0) $display("FAIL abort_ar_stable: got %0d violations expected 0", hold_viol); else passed++;
    r_dmin = 0; r_dmax = 0;
  endtask

  task automatic test_reset_mid();
    int a0, s0, d0;
    bit got;
    clr_models();
    ar_dmax = 0; r_dmin = 15; r_dmax = 15;
    a0 = ar_q.size(); s0 = st_q.size(); d0 = done_cnt;
    start_session(64'h5000, 32'd256, 32'd4);
    got = 1'b0;
    for (int c = 0; c < 50 && !got; c++) begin cyc(1); got = (ar_q.size() != a0); end
    total++; if (!got) $display("FAIL rstmid_handshake: got no read expected one"); else passed++;
    cyc(3);
    rst_n = 1'b0; fetch_enable = 1'b0;
    #1;
    total++; if ({kernel_start, fetch_done, fetch_error, axi.arvalid} !== '0)
      $display("FAIL rstmid_outputs: got %h expected 0", {kernel_start, fetch_done, fetch_error, axi.arvalid}); else passed++;
    total++; if (system_register !== '0) $display("FAIL rstmid_sysreg: got nonzero expected 0"); else passed++;
    cyc(2);
    rst_n = 1'b1;
    r_dmin = 0; r_dmax = 0;
    cyc(20);
    total++; if (st_q.size() != s0 || done_cnt != d0 || ar_q.size() - a0 != 1)
      $display("FAIL rstmid_quiet: got %0d starts %0d dones %0d reads expected 0 0 1",
               st_q.size() - s0, done_cnt - d0, ar_q.size() - a0); else passed++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_busy_wait();
    test_error();
    test_abort();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/job_fetcher.md
JOB_FETCHER -- requirements
Module: job_fetcher

Interface
REQ-001 Parameters: KERNEL_NUM (default 8, kernel count); ID_WIDTH (default 1, AXI ID width); ARUSER_WIDTH (default 8); DATA_WIDTH (default 512); ADDR_WIDTH (default 64).
REQ-002 clk  in  1  clock; all logic on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 fetch_enable  in  1  level; high = fetch session active.
REQ-005 job_addr  in  64  byte base of descriptor ring, 64B aligned.
REQ-006 job_size  in  32  ring size in bytes, nonzero multiple of 64.
REQ-007 job_count  in  32  descriptors to fetch this session.
REQ-008 kernel_busy  in  KERNEL_NUM  per-kernel busy; rises the cycle after that kernel's kernel_start.
REQ-009 kernel_start  out  KERNEL_NUM  one-hot, one-cycle start pulse.
REQ-010 system_register  out  512  last fetched descriptor; valid while kernel_start is high.
REQ-011 fetch_done  out  1  one-cycle pulse, session complete.
REQ-012 fetch_error  out  1  sticky error flag.
REQ-013 m_axi_ar*  out  AXI4 read address: arid, araddr, arlen, arsize, arburst, arcache, arlock, arprot, arqos, arregion, aruser, arvalid; arready in.
REQ-014 m_axi_r*  in  AXI4 read data: rid, rdata, rresp, rlast, rvalid; rready out.

Function
REQ-015 Constants: arid=0, arlen=0, arsize=3'b110, arburst=2'b01, arcache=4'b0011, arlock/arprot/arqos/arregion/aruser=0; rready=1 in every state.
REQ-016 FSM states: IDLE, ADDR, DATA, DISPATCH, DONE, ERROR.
REQ-017 IDLE->ADDR when fetch_enable=1, job_count!=0, session_done=0; on entry jobs_left<=job_count, rd_offset<=0.
REQ-018 ADDR: arvalid=1, araddr=job_addr+rd_offset; ->DATA on arvalid&arready; arvalid never deasserts before arready.
REQ-019 DATA: on rvalid with rresp=2'b00, latch rdata into system_register; ->DISPATCH; rresp!=00 ->ERROR.
REQ-020 DISPATCH: free = ~kernel_busy; pulse kernel_start for lowest-index free kernel for exactly one cycle; stay in DISPATCH while free==0.
REQ-021 Cycle after the kernel_start pulse: rd_offset <= (rd_offset+64==job_size) ? 0 : rd_offset+64; jobs_left decrements; ->DONE if jobs_left was 1, else ->ADDR.
REQ-022 Minimum spacing between kernel_start pulses: 2 cycles (kernel_busy settles before the next pick).
REQ-023 DONE: fetch_done=1 for one cycle; session_done<=1; ->IDLE.
REQ-024 session_done clears when fetch_enable=0; a new session needs fetch_enable low then high.
REQ-025 ERROR: fetch_error=1, no kernel_start; ->IDLE and fetch_error cleared when fetch_enable=0.
REQ-026 fetch_enable dropping in ADDR: hold arvalid until handshake; in DATA: consume the beat; then ->IDLE without dispatch; in DISPATCH: ->IDLE without pulse.
REQ-027 rd_offset is 32-bit; araddr sum is 64-bit, no carry check.
REQ-028 One read outstanding at most; rid ignored; rlast assumed 1.

Reset
REQ-029 Reset values: state=IDLE, kernel_start=0, system_register=0, fetch_done=0, fetch_error=0, arvalid=0, rd_offset=0, jobs_left=0, session_done=0.
REQ-030 Reset mid-transaction abandons the in-flight read; no output pulse follows reset release until a new session starts.

Structure
REQ-031 Shared package: FSM state encoding, DESC_BYTES=64, AR_SIZE_64B=3'b110, AXI constant values.
REQ-032 One sub-module, free_kernel_picker: combinational lowest-index one-hot select over ~kernel_busy plus an any_free output.

Verification
REQ-033 job_addr=0x1000, job_size=256, job_count=3, all idle -> araddr 0x1000, 0x1040, 0x1080; kernel_start 0x01, 0x02, 0x04; one fetch_done.
REQ-034 job_size=128, job_count=5 -> araddr sequence 0x1000, 0x1040, 0x1000, 0x1040, 0x1000 (wrap).
REQ-035 kernel_busy=0xFF for 20 cycles, then 0x7F -> no start during the wait; then kernel_start=0x80 with system_register = fetched rdata.
REQ-036 rresp=2'b10 on the second beat -> one start only, fetch_error=1 until fetch_enable=0, no fetch_done.
REQ-037 arready held low 10 cycles, fetch_enable dropped mid-wait -> arvalid held until handshake, beat consumed, no kernel_start, return to IDLE.
REQ-038 rst_n asserted in DATA -> all outputs return to reset values immediately; no start or done after release.
